spmv_row_sequencer: RTL and testbench
=====================================

// Module: spmv_row_sequencer
// PURPOSE
//  Sequences one sparse(CSR) x dense-vector product, row by row. Owns three single-port BRAMs:
//  row-pointer, nonzero (value+column) and dense vector. Drives the shared pipelined multiplier
//  (mult_gen_0-style, fixed latency) and accumulates products per row. Hands each row sum to the
//  result writer over a valid/ready handshake. Replaces hand-unrolled fixed-state read/multiply
//  sequencing with a pipelined, latency-tracked issue loop.
// PARAMETERS
//  ADDR_W   11  address width of all three BRAMs
//  DATA_W   32  operand width; product and accumulator are 2*DATA_W
//  RD_LAT   2   BRAM read latency in cycles (en/addr -> dout), >=1
//  MUL_LAT  6   multiplier latency in cycles (A/B -> P), >=1
// PORTS
//  clk         in   1         rising-edge clock
//  reset       in   1         synchronous, active-high reset
//  start       in   1         pulse: begin job; ignored unless busy=0
//  num_rows    in   ADDR_W    rows in job; 0 = empty job
//  busy        out  1         job in progress
//  done        out  1         one-cycle pulse after last row result accepted
//  ptr_en      out  1         row-pointer BRAM enable
//  ptr_addr    out  ADDR_W    row-pointer address (entries 0..num_rows)
//  ptr_din     in   ADDR_W    row-pointer read data
//  nz_en       out  1         nonzero BRAM enable
//  nz_addr     out  ADDR_W    nonzero index k
//  val_din     in   DATA_W    nonzero value[k]
//  col_din     in   ADDR_W    nonzero column[k]
//  dense_en    out  1         dense BRAM enable
//  dense_addr  out  ADDR_W    dense index (= column)
//  dense_din   in   DATA_W    dense[col]
//  mul_a       out  DATA_W    multiplier A (nonzero value)
//  mul_b       out  DATA_W    multiplier B (dense element)
//  mul_p       in   2*DATA_W  multiplier product, MUL_LAT after mul_a/mul_b
//  res_valid   out  1         row result valid; held until res_ready
//  res_ready   in   1         consumer accepts result when res_valid&&res_ready
//  res_row     out  ADDR_W    row index of result
//  res_data    out  2*DATA_W  row sum, unsigned, wraps modulo 2^(2*DATA_W)
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, valid pipeline cleared, accumulator 0. Reset mid-job aborts;
//   in-flight reads/products discarded; no done.
//  FSM: IDLE -start&&num_rows!=0-> PTR_LO; start&&num_rows==0 -> done pulse, stay IDLE.
//   PTR_LO: read ptr[r]; wait RD_LAT; latch k_lo -> PTR_HI. PTR_HI: read ptr[r+1]; latch k_hi.
//   k_hi<=k_lo (empty row) -> RESULT with sum 0; else -> ISSUE.
//   ISSUE: one nonzero read per cycle, k=k_lo..k_hi-1, nz_en=1; after last -> DRAIN.
//   DRAIN: wait until valid pipeline empty -> RESULT.
//   RESULT: res_valid=1, res_row=r, res_data=acc; on handshake: acc<=0, r<=r+1;
//   r+1==num_rows -> IDLE with done pulse, busy=0; else -> PTR_LO.
//  Pipeline per issued k (cycle t): col_din/val_din valid t+RD_LAT -> dense_en/dense_addr driven same
//   cycle; val delayed RD_LAT to align; mul_a/mul_b registered at t+2*RD_LAT;
//   mul_p consumed at t+2*RD_LAT+MUL_LAT. A 1-bit valid shift register of length 2*RD_LAT+MUL_LAT
//   tracks each issue; acc += mul_p only when tap valid. mul_a/mul_b = 0 when no valid op.
//  Throughput: 1 nonzero/cycle in ISSUE; per-row overhead 2*RD_LAT + pipeline depth + 1.
//  res_ready low: FSM stalls in RESULT, res_* stable, no new issues.
//  Row pointers: k_hi<k_lo treated as empty row; nz_addr wraps modulo 2^ADDR_W.
//  start while busy: ignored. busy=1 from cycle after accepted start until done cycle.
// CONFIGURATION
//  SPMV_ZERO_SKIP_EN defined: nonzero with val_din==0 marks its pipeline slot invalid at t+RD_LAT
//   (dense_en stays 0, no accumulate); issue rate unchanged; sum unchanged.
//  Not defined: every stored entry fetched and multiplied, including explicit zeros.
// TESTING
//  num_rows=1, ptr={0,3}, val={2,3,4}, col={0,1,2}, dense={1,2,3} -> one result row0 = 20, done.
//  num_rows=3, ptr={0,0,1,1}, val={5}, col={7}, dense[7]=6 -> rows 0,1,2 = 0,30,0 in order.
//  res_ready low 10 cycles in RESULT -> res_valid/res_row/res_data held constant, no extra issues.
//  val=0xFFFFFFFF, dense=0xFFFFFFFF, 2 nonzeros -> res_data = 2*0xFFFFFFFE00000001 mod 2^64.
//  reset asserted mid-ISSUE then new start -> first result reflects only new job, no stray done.
//  SPMV_ZERO_SKIP_EN with val={0,7}, col={1,2}, dense={_,9,4} -> sum 28, one dense_en pulse only.

Source files
------------

// File: rtl/spmv_row_sequencer.sv
// CSR sparse-matrix x dense-vector row sequencer: pointer fetch, pipelined nonzero issue,
// latency-tracked multiply/accumulate, valid/ready row results. Option: SPMV_ZERO_SKIP_EN.
module spmv_row_sequencer #(
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 32,
  parameter int RD_LAT  = 2,
  parameter int MUL_LAT = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   num_rows,
  output logic                busy,
  output logic                done,
  output logic                ptr_en,
  output logic [ADDR_W-1:0]   ptr_addr,
  input  logic [ADDR_W-1:0]   ptr_din,
  output logic                nz_en,
  output logic [ADDR_W-1:0]   nz_addr,
  input  logic [DATA_W-1:0]   val_din,
  input  logic [ADDR_W-1:0]   col_din,
  output logic                dense_en,
  output logic [ADDR_W-1:0]   dense_addr,
  input  logic [DATA_W-1:0]   dense_din,
  output logic [DATA_W-1:0]   mul_a,
  output logic [DATA_W-1:0]   mul_b,
  input  logic [2*DATA_W-1:0] mul_p,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [ADDR_W-1:0]   res_row,
  output logic [2*DATA_W-1:0] res_data
);
  localparam int DEPTH = 2*RD_LAT + MUL_LAT;
  localparam int CW    = $clog2(RD_LAT+1) + 1;

  typedef enum logic [2:0] {IDLE, PTR_LO, PTR_HI, ISSUE, DRAIN, RESULT} state_t;
  state_t state, state_nx;

  logic [ADDR_W-1:0]              rows_q, r, k, k_lo, k_hi;
  logic [CW-1:0]                  cnt;
  logic [DEPTH:1]                 vld_pipe;  // bit d: op issued d cycles ago
  logic [RD_LAT-1:0][DATA_W-1:0]  val_dly;
  logic [2*DATA_W-1:0]            acc;
  logic                           issue, rd_done, last_row, nz_ok;

  assign rd_done  = (cnt == CW'(RD_LAT));
  assign last_row = ((r + ADDR_W'(1)) == rows_q);
  assign busy     = (state != IDLE);

`ifdef SPMV_ZERO_SKIP_EN
  assign nz_ok = (val_din != '0);
`else
  assign nz_ok = 1'b1;
`endif

  assign dense_en   = vld_pipe[RD_LAT] && nz_ok;
  assign dense_addr = dense_en ? col_din : '0;
  assign mul_a      = vld_pipe[2*RD_LAT] ? val_dly[RD_LAT-1] : '0;
  assign mul_b      = vld_pipe[2*RD_LAT] ? dense_din : '0;

  always_comb begin
    state_nx  = state;
    ptr_en    = 1'b0;
    ptr_addr  = '0;
    nz_en     = 1'b0;
    nz_addr   = '0;
    issue     = 1'b0;
    res_valid = 1'b0;
    res_row   = '0;
    res_data  = '0;
    case (state)
      IDLE:   if (start && num_rows != '0) state_nx = PTR_LO;
      PTR_LO: begin
        ptr_en   = (cnt == '0);
        ptr_addr = r;
        if (rd_done) state_nx = PTR_HI;
      end
      PTR_HI: begin
        ptr_en   = (cnt == '0);
        ptr_addr = r + ADDR_W'(1);
        // k_hi <= k_lo covers both empty and inverted pointer pairs
        if (rd_done) state_nx = (ptr_din <= k_lo) ? RESULT : ISSUE;
      end
      ISSUE: begin
        nz_en   = 1'b1;
        nz_addr = k;
        issue   = 1'b1;
        if ((k + ADDR_W'(1)) == k_hi) state_nx = DRAIN;
      end
      DRAIN:  if (vld_pipe == '0) state_nx = RESULT;
      RESULT: begin
        res_valid = 1'b1;
        res_row   = r;
        res_data  = acc;
        if (res_ready) state_nx = last_row ? IDLE : PTR_LO;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rows_q   <= '0;
      r        <= '0;
      k        <= '0;
      k_lo     <= '0;
      k_hi     <= '0;
      cnt      <= '0;
      vld_pipe <= '0;
      val_dly  <= '0;
      acc      <= '0;
      done     <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= 1'b0;

      vld_pipe[1] <= issue;
      for (int i = 2; i <= DEPTH; i++) vld_pipe[i] <= vld_pipe[i-1];
`ifdef SPMV_ZERO_SKIP_EN
      vld_pipe[RD_LAT+1] <= vld_pipe[RD_LAT] && nz_ok;
`endif
      val_dly[0] <= val_din;
      for (int i = 1; i < RD_LAT; i++) val_dly[i] <= val_dly[i-1];

      if (vld_pipe[DEPTH]) acc <= acc + mul_p;

      case (state)
        IDLE: begin
          cnt <= '0;
          if (start) begin
            if (num_rows == '0) done <= 1'b1;
            rows_q <= num_rows;
            r      <= '0;
            acc    <= '0;
          end
        end
        PTR_LO: begin
          cnt <= rd_done ? '0 : cnt + CW'(1);
          if (rd_done) k_lo <= ptr_din;
        end
        PTR_HI: begin
          cnt <= rd_done ? '0 : cnt + CW'(1);
          if (rd_done) begin
            k_hi <= ptr_din;
            k    <= k_lo;
          end
        end
        ISSUE:  k <= k + ADDR_W'(1);
        RESULT: if (res_ready) begin
          acc <= '0;
          r   <= r + ADDR_W'(1);
          if (last_row) done <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_spmv_row_sequencer.sv
// Bench for spmv_row_sequencer: BRAM/multiplier models, CSR row-sum scoreboard, directed jobs.
// Honours SPMV_ZERO_SKIP_EN when the macro is defined for the build.
module tb_spmv_row_sequencer;
  localparam int ADDR_W = 11, DATA_W = 32, RD_LAT = 2, MUL_LAT = 6;
  localparam int MEM_N  = 1 << ADDR_W;

  logic clk, reset, start, busy, done;
  logic [ADDR_W-1:0] num_rows, ptr_addr, ptr_din, nz_addr, col_din, dense_addr, res_row;
  logic ptr_en, nz_en, dense_en, res_valid, res_ready;
  logic [DATA_W-1:0] val_din, dense_din, mul_a, mul_b;
  logic [2*DATA_W-1:0] mul_p, res_data;

  spmv_row_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .num_rows(num_rows), .busy(busy), .done(done),
    .ptr_en(ptr_en), .ptr_addr(ptr_addr), .ptr_din(ptr_din),
    .nz_en(nz_en), .nz_addr(nz_addr), .val_din(val_din), .col_din(col_din),
    .dense_en(dense_en), .dense_addr(dense_addr), .dense_din(dense_din),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .res_valid(res_valid), .res_ready(res_ready), .res_row(res_row), .res_data(res_data));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [ADDR_W-1:0] ptr_mem [MEM_N];
  logic [DATA_W-1:0] val_mem [MEM_N];
  logic [ADDR_W-1:0] col_mem [MEM_N];
  logic [DATA_W-1:0] dense_mem [MEM_N];

  // memories and multiplier with their stated latencies
  logic [ADDR_W-1:0] ptr_q [RD_LAT];
  logic [DATA_W-1:0] val_q [RD_LAT];
  logic [ADDR_W-1:0] col_q [RD_LAT];
  logic [DATA_W-1:0] dns_q [RD_LAT];
  logic [2*DATA_W-1:0] mp_q [MUL_LAT];
  always @(posedge clk) begin
    ptr_q[0] <= ptr_en ? ptr_mem[ptr_addr] : '0;
    val_q[0] <= nz_en ? val_mem[nz_addr] : '0;
    col_q[0] <= nz_en ? col_mem[nz_addr] : '0;
    dns_q[0] <= dense_en ? dense_mem[dense_addr] : '0;
    for (int i = 1; i < RD_LAT; i++) begin
      ptr_q[i] <= ptr_q[i-1]; val_q[i] <= val_q[i-1];
      col_q[i] <= col_q[i-1]; dns_q[i] <= dns_q[i-1];
    end
    mp_q[0] <= 64'(mul_a) * 64'(mul_b);
    for (int i = 1; i < MUL_LAT; i++) mp_q[i] <= mp_q[i-1];
  end
  assign ptr_din   = ptr_q[RD_LAT-1];
  assign val_din   = val_q[RD_LAT-1];
  assign col_din   = col_q[RD_LAT-1];
  assign dense_din = dns_q[RD_LAT-1];
  assign mul_p     = mp_q[MUL_LAT-1];

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // row r sum straight from the CSR definition
  function automatic logic [63:0] row_sum(input int r);
    logic [ADDR_W-1:0] lo, hi;
    logic [63:0] s;
    lo = ptr_mem[r]; hi = ptr_mem[r+1]; s = '0;
    if (hi > lo)
      for (int kk = int'(lo); kk < int'(hi); kk++)
        s += 64'(val_mem[kk]) * 64'(dense_mem[col_mem[kk]]);
    return s;
  endfunction

  typedef struct { logic [ADDR_W-1:0] row; logic [63:0] data; bit last; } exp_t;
  exp_t exp_q[$];
  bit allow_empty = 0;
  logic [63:0] last_data = '0;
  int nz_cnt = 0, dense_cnt = 0;

  always @(negedge clk) begin
    if (nz_en) nz_cnt++;
    if (dense_en) dense_cnt++;
  end

  bit exp_done = 0, pv = 0, pr = 0;
  logic [ADDR_W-1:0] prow;
  logic [63:0] pdata;
  exp_t e;
  always @(negedge clk) begin
    if (reset) begin
      exp_done = 0; pv = 0;
    end else begin
      if (exp_done || (done && !allow_empty)) chk("done_pulse", 64'(done), 64'(exp_done));
      exp_done = 0;
      if (pv && !pr) begin
        chk("hold_valid", 64'(res_valid), 64'd1);
        chk("hold_row", 64'(res_row), 64'(prow));
        chk("hold_data", res_data, pdata);
      end
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) chk("extra_result", 64'(exp_q.size()), 64'd1);
        else begin
          e = exp_q.pop_front();
          chk("res_row", 64'(res_row), 64'(e.row));
          chk("res_data", res_data, e.data);
          last_data = res_data;
          exp_done = e.last;
        end
      end
      pv = res_valid; pr = res_ready; prow = res_row; pdata = res_data;
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < MEM_N; i++) begin
      ptr_mem[i] = '0; val_mem[i] = '0; col_mem[i] = '0; dense_mem[i] = '0;
    end
  endtask

  // mode 0: ready high, 1: random ready, 2: ready low for 10 cycles of first result
  task automatic run_job(input int n, input int mode, input bit poke,
                         output int dense_n, output int stall_nz);
    int d0, nz0, stall;
    bit got, released;
    for (int r = 0; r < n; r++) exp_q.push_back('{row: ADDR_W'(r), data: row_sum(r), last: (r == n-1)});
    d0 = dense_cnt; stall = 0; released = 0; got = 0; nz0 = 0; stall_nz = -1;
    res_ready = (mode != 2);
    @(posedge clk); #1; start = 1; num_rows = ADDR_W'(n);
    @(posedge clk); #1; start = 0; num_rows = '0;
    chk("busy_after_start", 64'(busy), 64'd1);
    for (int c = 0; c < 4000; c++) begin
      case (mode)
        0: res_ready = 1;
        1: res_ready = 1'($urandom_range(0, 1));
        default: begin
          if (!released && res_valid) begin
            if (stall == 0) nz0 = nz_cnt;
            if (stall == 10) begin released = 1; stall_nz = nz_cnt - nz0; end
            stall++;
          end
          res_ready = released;
        end
      endcase
      start = poke && (c == 5);
      num_rows = start ? ADDR_W'(7) : '0;
      @(posedge clk); #1;
      if (done) begin got = 1; break; end
    end
    start = 0; res_ready = 1;
    chk("done_seen", 64'(got), 64'd1);
    chk("busy_at_done", 64'(busy), 64'd0);
    chk("rows_left", 64'(exp_q.size()), 64'd0);
    dense_n = dense_cnt - d0;
  endtask

  int dn, snz;
  bit seen;
  initial begin
    reset = 1; start = 0; num_rows = '0; res_ready = 1;
    clear_mem();
    repeat (3) @(posedge clk);
    #1 reset = 0;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ptr_en", 64'(ptr_en), 64'd0);
    chk("rst_nz_en", 64'(nz_en), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_mul", 64'({mul_a, mul_b}), 64'd0);
    chk("rst_res_data", res_data, 64'd0);

    // one row, three nonzeros
    ptr_mem[0] = 0; ptr_mem[1] = 3;
    val_mem[0] = 2; val_mem[1] = 3; val_mem[2] = 4;
    col_mem[0] = 0; col_mem[1] = 1; col_mem[2] = 2;
    dense_mem[0] = 1; dense_mem[1] = 2; dense_mem[2] = 3;
    chk("model_t1", row_sum(0), 64'd20);
    run_job(1, 0, 0, dn, snz);
    chk("t1_result", last_data, 64'd20);

    // same job with ready held low while the result waits
    run_job(1, 2, 0, dn, snz);
    chk("stall_no_issue", 64'(snz), 64'd0);

    // empty rows around a single-nonzero row
    clear_mem();
    ptr_mem[0] = 0; ptr_mem[1] = 0; ptr_mem[2] = 1; ptr_mem[3] = 1;
    val_mem[0] = 5; col_mem[0] = 7; dense_mem[7] = 6;
    chk("model_t2_row1", row_sum(1), 64'd30);
    chk("model_t2_row2", row_sum(2), 64'd0);
    run_job(3, 0, 0, dn, snz);

    // full-scale operands, wraps modulo 2^64
    clear_mem();
    ptr_mem[0] = 0; ptr_mem[1] = 2;
    val_mem[0] = '1; val_mem[1] = '1; col_mem[1] = 1;
    dense_mem[0] = '1; dense_mem[1] = '1;
    chk("model_big", row_sum(0), 64'hFFFF_FFFC_0000_0002);
    run_job(1, 0, 0, dn, snz);
    chk("big_result", last_data, 64'hFFFF_FFFC_0000_0002);

    // inverted pointer pair, random ready, start poked mid-job
    clear_mem();
    ptr_mem[0] = 0; ptr_mem[1] = 1; ptr_mem[2] = 4; ptr_mem[3] = 2; ptr_mem[4] = 9;
    for (int i = 0; i < 9; i++) begin
      val_mem[i] = 32'(100 + 7*i); col_mem[i] = ADDR_W'(3*i + 1); dense_mem[3*i + 1] = 32'(i + 2);
    end
    chk("model_inverted", row_sum(2), 64'd0);
    run_job(4, 1, 1, dn, snz);

    // empty job: done pulse only
    allow_empty = 1;
    @(posedge clk); #1; start = 1; num_rows = '0;
    @(posedge clk); #1; start = 0;
    chk("empty_done", 64'(done), 64'd1);
    chk("empty_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    chk("empty_done_clear", 64'(done), 64'd0);
    allow_empty = 0;

    // abort a long row mid-issue, then run a fresh job
    clear_mem();
    ptr_mem[0] = 0; ptr_mem[1] = 20;
    for (int i = 0; i < 20; i++) begin val_mem[i] = 9; dense_mem[i] = 9; col_mem[i] = ADDR_W'(i); end
    @(posedge clk); #1; start = 1; num_rows = 1;
    @(posedge clk); #1; start = 0; num_rows = '0;
    seen = 0;
    for (int c = 0; c < 50 && !seen; c++) begin @(posedge clk); #1; seen = nz_en; end
    chk("abort_reached_issue", 64'(seen), 64'd1);
    repeat (3) @(posedge clk);
    #1 reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_valid", 64'(res_valid), 64'd0);
    repeat (20) @(posedge clk);
    #1;
    clear_mem();
    ptr_mem[0] = 0; ptr_mem[1] = 2;
    val_mem[0] = 3; val_mem[1] = 4; col_mem[0] = 5; col_mem[1] = 6;
    dense_mem[5] = 10; dense_mem[6] = 1;
    run_job(1, 0, 0, dn, snz);
    chk("after_abort_result", last_data, 64'd34);

    // explicit zero value
    clear_mem();
    ptr_mem[0] = 0; ptr_mem[1] = 2;
    val_mem[0] = 0; val_mem[1] = 7; col_mem[0] = 1; col_mem[1] = 2;
    dense_mem[1] = 9; dense_mem[2] = 4;
    run_job(1, 0, 0, dn, snz);
    chk("zero_val_result", last_data, 64'd28);
`ifdef SPMV_ZERO_SKIP_EN
    chk("dense_reads", 64'(dn), 64'd1);
`else
    chk("dense_reads", 64'(dn), 64'd2);
`endif

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
